// File: rtl/otbn_loop_prefetch_ctrl.sv
// Hardware-loop stack for OTBN: tracks nested LOOP/LOOPI bodies, feeds the prefetch
// loop hints to fetch and redirects the PC on committed end-of-body instructions.
module otbn_loop_prefetch_ctrl #(
    parameter int ImemSizeByte   = 4096,
    parameter int LoopStackDepth = 8,
    localparam int ImemAddrWidth = (ImemSizeByte > 1) ? $clog2(ImemSizeByte) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     insn_valid_i,
    input  logic                     insn_stall_i,
    input  logic [ImemAddrWidth-1:0] insn_addr_i,
    input  logic                     loop_start_i,
    input  logic [11:0]              loop_bodysize_i,
    input  logic [31:0]              loop_iterations_i,
    input  logic                     state_reset_i,
    output logic                     loop_jump_o,
    output logic [ImemAddrWidth-1:0] loop_jump_addr_o,
    output logic                     prefetch_loop_active_o,
    output logic [31:0]              prefetch_loop_iterations_o,
    output logic [ImemAddrWidth:0]   prefetch_loop_end_addr_o,
    output logic [ImemAddrWidth-1:0] prefetch_loop_jump_addr_o,
    output logic                     loop_err_o,
    output logic [2:0]               loop_err_code_o
);

    localparam int CntWidth = $clog2(LoopStackDepth + 1);
    localparam logic [CntWidth-1:0]    CntFull   = CntWidth'(LoopStackDepth);
    localparam logic [ImemAddrWidth:0] ImemLimit = (ImemAddrWidth + 1)'(ImemSizeByte);

    typedef struct packed {
        logic [ImemAddrWidth-1:0] start_addr;
        logic [ImemAddrWidth:0]   end_addr;
        logic [31:0]              iter;
    } loop_entry_t;

    // The top entry lives in its own register so the prefetch hints come straight
    // from flops; the entries beneath it form a shift stack (below_q[0] is next).
    loop_entry_t         top_q;
    loop_entry_t         below_q [LoopStackDepth-1];
    logic [CntWidth-1:0] cnt_q;

    logic        active;
    logic        full;
    logic        commit;
    logic        at_end;
    logic        push_req;
    logic        do_push;
    logic        do_jump;
    logic        do_pop;
    logic [2:0]  err_code;
    logic [13:0] body_bytes;
    loop_entry_t new_entry;

    function automatic logic [2:0] push_check(
        input logic                   full_f,
        input logic                   active_f,
        input logic                   at_end_f,
        input logic [31:0]            iter_f,
        input logic [11:0]            bodysize_f,
        input logic [ImemAddrWidth:0] end_f,
        input logic [ImemAddrWidth:0] top_end_f
    );
        logic [2:0] code;
        if (full_f) begin
            code = 3'd1;
        end else if (iter_f == 32'd0) begin
            code = 3'd2;
        end else if (bodysize_f == 12'd0) begin
            code = 3'd3;
        end else if (end_f[ImemAddrWidth] || (end_f >= ImemLimit)) begin
            code = 3'd4;
        end else if (at_end_f || (active_f && (end_f >= top_end_f))) begin
            code = 3'd5;
        end else begin
            code = 3'd0;
        end
        return code;
    endfunction

    assign active   = (cnt_q != '0);
    assign full     = (cnt_q == CntFull);
    assign commit   = insn_valid_i & ~insn_stall_i;
    assign at_end   = commit & active & (insn_addr_i == top_q.end_addr[ImemAddrWidth-1:0]);
    assign push_req = commit & loop_start_i;

    assign body_bytes = {loop_bodysize_i, 2'b00};

    always_comb begin
        new_entry.start_addr = insn_addr_i + ImemAddrWidth'(4);
        new_entry.end_addr   = {1'b0, insn_addr_i} + (ImemAddrWidth + 1)'(body_bytes);
        new_entry.iter       = loop_iterations_i;
    end

    always_comb begin
        err_code = 3'd0;
        if (push_req) begin
            err_code = push_check(full, active, at_end, loop_iterations_i, loop_bodysize_i,
                                  new_entry.end_addr, top_q.end_addr);
        end
    end

    // A LOOP sitting on the end address is a nesting error, so end handling is skipped.
    assign do_push = push_req & (err_code == 3'd0);
    assign do_jump = at_end & ~loop_start_i & (top_q.iter > 32'd1);
    assign do_pop  = at_end & ~loop_start_i & ~(top_q.iter > 32'd1);

    assign loop_jump_o      = do_jump;
    assign loop_jump_addr_o = do_jump ? top_q.start_addr : '0;
    assign loop_err_o       = (err_code != 3'd0);
    assign loop_err_code_o  = err_code;

    assign prefetch_loop_active_o     = active;
    assign prefetch_loop_iterations_o = top_q.iter;
    assign prefetch_loop_end_addr_o   = top_q.end_addr;
    assign prefetch_loop_jump_addr_o  = top_q.start_addr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            top_q <= '0;
        end else if (state_reset_i) begin
            cnt_q <= '0;
            top_q <= '0;
        end else if (do_push) begin
            cnt_q <= cnt_q + CntWidth'(1);
            top_q <= new_entry;
        end else if (do_jump) begin
            top_q.iter <= top_q.iter - 32'd1;
        end else if (do_pop) begin
            cnt_q <= cnt_q - CntWidth'(1);
            top_q <= (cnt_q > CntWidth'(1)) ? below_q[0] : '0;
        end
    end

    // Entries beyond the occupancy count are don't-care, so the shift stack needs no reset.
    always_ff @(posedge clk_i) begin
        if (!state_reset_i) begin
            if (do_push) begin
                below_q[0] <= top_q;
                for (int i = 1; i < LoopStackDepth - 1; i++) begin
                    below_q[i] <= below_q[i-1];
                end
            end else if (do_pop) begin
                for (int i = 0; i < LoopStackDepth - 2; i++) begin
                    below_q[i] <= below_q[i+1];
                end
            end
        end
    end

endmodule
